// File: rtl/x_debouncer.sv
// x_debouncer: synchronizes a raw pad/switch level and accepts a new level
// only after it has been seen for STABLE_CYCLES consecutive synchronized
// cycles. Produces the debounced level x plus one-cycle rise/fall pulses
// and a busy flag while a change is pending.
module x_debouncer #(
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic x,
  output logic rise,
  output logic fall,
  output logic busy
);

  typedef enum logic {
    STABLE  = 1'b0,
    PENDING = 1'b1
  } state_t;

  // Terminal count: the value cnt holds on the edge that accepts the new level.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic             sync_reg [SYNC_STAGES];
  logic             s;
  state_t           state_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             x_reg;
  logic             rise_reg;
  logic             fall_reg;
  logic             busy_reg;

  // Synchronizer chain; din is read only by the first stage.
  generate
    for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
      if (gi == 0) begin : g_first
        // First stage samples the asynchronous pad level.
        always_ff @(posedge clk) begin
          if (!reset) sync_reg[gi] <= 1'b0;
          else        sync_reg[gi] <= din;
        end
      end else begin : g_rest
        // Later stages shift the level down the chain.
        always_ff @(posedge clk) begin
          if (!reset) sync_reg[gi] <= 1'b0;
          else        sync_reg[gi] <= sync_reg[gi-1];
        end
      end
    end
  endgenerate

  assign s = sync_reg[SYNC_STAGES-1];

  // Debounce FSM: counts consecutive cycles where s differs from x and
  // commits s to x (with an edge pulse) once the count is complete.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg <= STABLE;
      cnt_reg   <= '0;
      x_reg     <= 1'b0;
      rise_reg  <= 1'b0;
      fall_reg  <= 1'b0;
      busy_reg  <= 1'b0;
    end else begin
      rise_reg <= 1'b0;
      fall_reg <= 1'b0;
      if (state_reg == STABLE) begin
        if (s != x_reg) begin
          if (STABLE_CYCLES == 1) begin
            // A single synchronized cycle is enough: accept immediately.
            x_reg    <= s;
            rise_reg <= s;
            fall_reg <= ~s;
            cnt_reg  <= '0;
          end else begin
            state_reg <= PENDING;
            cnt_reg   <= CNT_ONE;
            busy_reg  <= 1'b1;
          end
        end
      end else begin
        if (s == x_reg) begin
          // Glitch ended before the count completed: drop it silently.
          state_reg <= STABLE;
          cnt_reg   <= '0;
          busy_reg  <= 1'b0;
        end else if (cnt_reg == CNT_LAST) begin
          state_reg <= STABLE;
          cnt_reg   <= '0;
          busy_reg  <= 1'b0;
          x_reg     <= s;
          rise_reg  <= s;
          fall_reg  <= ~s;
        end else begin
          cnt_reg <= cnt_reg + CNT_ONE;
        end
      end
    end
  end

  assign x    = x_reg;
  assign rise = rise_reg;
  assign fall = fall_reg;
  assign busy = busy_reg;

endmodule

// File: tb/tb_x_debouncer.sv
// Directed testbench for x_debouncer: default instance plus a
// STABLE_CYCLES=1 instance driven by the same din.
module tb_x_debouncer;

  logic clk;
  logic reset;
  logic din;
  logic x0, rise0, fall0, busy0;
  logic x1, rise1, fall1, busy1;

  int checks;
  int errors;

  x_debouncer dut (
    .clk   (clk),
    .reset (reset),
    .din   (din),
    .x     (x0),
    .rise  (rise0),
    .fall  (fall0),
    .busy  (busy0)
  );

  x_debouncer #(
    .SYNC_STAGES  (2),
    .STABLE_CYCLES(1),
    .CNT_W        (8)
  ) dut1 (
    .clk   (clk),
    .reset (reset),
    .din   (din),
    .x     (x1),
    .rise  (rise1),
    .fall  (fall1),
    .busy  (busy1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [3:0] exp_v;
    reset = 1'b0;
    din   = 1'b0;
    tick();
    tick();
    exp_v = 4'b0000;
    checks++;
    if ({x0, rise0, fall0, busy0} !== exp_v) begin
      errors++;
      $display("FAIL reset_outputs got=%b exp=%b", {x0, rise0, fall0, busy0}, exp_v);
    end
    checks++;
    if ({x1, rise1, fall1, busy1} !== exp_v) begin
      errors++;
      $display("FAIL reset_outputs_sc1 got=%b exp=%b", {x1, rise1, fall1, busy1}, exp_v);
    end
    checks++;
    if (dut.cnt_reg !== 8'd0) begin
      errors++;
      $display("FAIL reset_cnt got=%0d exp=0", dut.cnt_reg);
    end
    reset = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    checks++;
    if ({x0, rise0, fall0, busy0} !== exp_v) begin
      errors++;
      $display("FAIL idle_after_reset got=%b exp=%b", {x0, rise0, fall0, busy0}, exp_v);
    end
    $display("test_reset done");
  endtask

  // din 0->1 held: x/rise on edge 6 (edge 3 for single-cycle instance).
  task automatic test_rise();
    logic [3:0] exp0, exp1;
    din = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      tick();
      exp0 = {e >= 6, e == 6, 1'b0, (e >= 3 && e <= 5)};
      exp1 = {e >= 3, e == 3, 1'b0, 1'b0};
      checks++;
      if ({x0, rise0, fall0, busy0} !== exp0) begin
        errors++;
        $display("FAIL rise_edge%0d got=%b exp=%b", e, {x0, rise0, fall0, busy0}, exp0);
      end
      checks++;
      if ({x1, rise1, fall1, busy1} !== exp1) begin
        errors++;
        $display("FAIL rise_sc1_edge%0d got=%b exp=%b", e, {x1, rise1, fall1, busy1}, exp1);
      end
    end
    $display("test_rise done");
  endtask

  // din 1->0 held: x/fall on edge 6, no rise.
  task automatic test_fall();
    logic [3:0] exp0, exp1;
    din = 1'b0;
    for (int e = 1; e <= 8; e++) begin
      tick();
      exp0 = {e < 6, 1'b0, e == 6, (e >= 3 && e <= 5)};
      exp1 = {e < 3, 1'b0, e == 3, 1'b0};
      checks++;
      if ({x0, rise0, fall0, busy0} !== exp0) begin
        errors++;
        $display("FAIL fall_edge%0d got=%b exp=%b", e, {x0, rise0, fall0, busy0}, exp0);
      end
      checks++;
      if ({x1, rise1, fall1, busy1} !== exp1) begin
        errors++;
        $display("FAIL fall_sc1_edge%0d got=%b exp=%b", e, {x1, rise1, fall1, busy1}, exp1);
      end
    end
    $display("test_fall done");
  endtask

  // din high 3 cycles then low: default x never moves; single-cycle follows.
  task automatic test_short_glitch();
    logic [3:0] exp0, exp1;
    for (int e = 1; e <= 10; e++) begin
      din = (e <= 3);
      tick();
      exp0 = {1'b0, 1'b0, 1'b0, (e >= 3 && e <= 5)};
      exp1 = {(e >= 3 && e < 6), e == 3, e == 6, 1'b0};
      checks++;
      if ({x0, rise0, fall0, busy0} !== exp0) begin
        errors++;
        $display("FAIL short_glitch_edge%0d got=%b exp=%b", e, {x0, rise0, fall0, busy0}, exp0);
      end
      checks++;
      if ({x1, rise1, fall1, busy1} !== exp1) begin
        errors++;
        $display("FAIL short_glitch_sc1_edge%0d got=%b exp=%b", e, {x1, rise1, fall1, busy1}, exp1);
      end
    end
    checks++;
    if (dut.cnt_reg !== 8'd0) begin
      errors++;
      $display("FAIL short_glitch_cnt got=%0d exp=0", dut.cnt_reg);
    end
    $display("test_short_glitch done");
  endtask

  // din high with a 1-cycle low at sampling edge 4: count restarts, x at edge 10.
  task automatic test_glitch_restart();
    logic [3:0] exp0;
    for (int e = 1; e <= 12; e++) begin
      din = (e != 4);
      tick();
      exp0 = {e >= 10, e == 10, 1'b0, ((e >= 3 && e <= 5) || (e >= 7 && e <= 9))};
      checks++;
      if ({x0, rise0, fall0, busy0} !== exp0) begin
        errors++;
        $display("FAIL glitch_restart_edge%0d got=%b exp=%b", e, {x0, rise0, fall0, busy0}, exp0);
      end
    end
    din = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    checks++;
    if ({x0, rise0, fall0, busy0} !== 4'b0000) begin
      errors++;
      $display("FAIL glitch_restart_return got=%b exp=0000", {x0, rise0, fall0, busy0});
    end
    $display("test_glitch_restart done");
  endtask

  // Reset while PENDING cancels the change; after release x rises on edge 6.
  task automatic test_reset_pending();
    logic [3:0] exp0;
    din = 1'b1;
    for (int e = 1; e <= 3; e++) tick();
    checks++;
    if ({x0, busy0} !== 2'b01) begin
      errors++;
      $display("FAIL pending_before_reset got=%b exp=01", {x0, busy0});
    end
    reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if ({x0, rise0, fall0, busy0, x1, rise1, fall1, busy1} !== 8'h00) begin
        errors++;
        $display("FAIL reset_in_pending_%0d got=%b exp=00000000", i,
                 {x0, rise0, fall0, busy0, x1, rise1, fall1, busy1});
      end
      checks++;
      if (dut.cnt_reg !== 8'd0) begin
        errors++;
        $display("FAIL reset_in_pending_cnt got=%0d exp=0", dut.cnt_reg);
      end
    end
    reset = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      tick();
      exp0 = {e >= 6, e == 6, 1'b0, (e >= 3 && e <= 5)};
      checks++;
      if ({x0, rise0, fall0, busy0} !== exp0) begin
        errors++;
        $display("FAIL after_release_edge%0d got=%b exp=%b", e, {x0, rise0, fall0, busy0}, exp0);
      end
    end
    $display("test_reset_pending done");
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b0;
    din    = 1'b0;
    test_reset();
    test_rise();
    test_fall();
    test_short_glitch();
    test_glitch_restart();
    test_reset_pending();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
